// File: rtl/lut.sv
// lut: four-input lookup table cell, SB_LUT4 ordering, with a clocked copy of the result.
// Define LUT_REG_OUT_EN to register q; without it q mirrors o and clk/rst_n/ce are ignored.
module lut #(
  parameter logic [15:0] LUT = 16'h0000
) (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic o,
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  output logic q
);

  logic [7:0] s1;
  logic [3:0] s2;
  logic [1:0] s3;

  // Mux tree: an unknown select merges both legs, so matching leaves stay known.
  for (genvar i = 0; i < 8; i++) begin : g_s1
    assign s1[i] = a ? LUT[2*i+1] : LUT[2*i];
  end

  for (genvar i = 0; i < 4; i++) begin : g_s2
    assign s2[i] = b ? s1[2*i+1] : s1[2*i];
  end

  for (genvar i = 0; i < 2; i++) begin : g_s3
    assign s3[i] = c ? s2[2*i+1] : s2[2*i];
  end

  assign o = d ? s3[1] : s3[0];

`ifdef LUT_REG_OUT_EN
  logic q_q;
  logic q_d;
  logic ce_en;

  // A floating enable loads, like an unconnected CE pin on silicon.
  assign ce_en = (ce !== 1'b0);
  assign q_d   = ce_en ? o : q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
`else
  logic unused_ctl;

  assign unused_ctl = ^{clk, rst_n, ce};
  assign q = o;
`endif

endmodule

// File: tb/tb_lut.sv
// tb_lut: random and directed checks of lut against a Boolean reference model.
// Five table instances share one input bus; q checks follow the LUT_REG_OUT_EN build.
module tb_lut;

  localparam int N = 5;
  localparam logic [15:0] TBL [N] = '{16'hFFD2, 16'h0001, 16'h8000,
                                      16'hAAAA, 16'h6996};

  logic a, b, c, d;
  logic clk, rst_n, ce;
  logic [N-1:0] o_v, q_v;
  logic exp_q [N];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    lut #(.LUT(TBL[g])) u_dut (
      .a(a), .b(b), .c(c), .d(d), .o(o_v[g]),
      .clk(clk), .rst_n(rst_n), .ce(ce), .q(q_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Intended function of each instance, written as plain Boolean algebra.
  function automatic logic f_bool(int k, logic [3:0] i);
    logic fa, fb, fc, fd;
    {fd, fc, fb, fa} = i;
    case (k)
      0: return ((fa & ~fb) ^ fc) | fd;
      1: return ~(fa | fb | fc | fd);
      2: return fa & fb & fc & fd;
      3: return fa;
      default: return fa ^ fb ^ fc ^ fd;
    endcase
  endfunction

  // Resolve unknown selects by enumerating every consistent input.
  function automatic logic ref_o(int k, logic [3:0] s);
    logic seen0, seen1, ok;
    logic [3:0] iv;
    seen0 = 1'b0;
    seen1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      ok = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (s[j] === 1'b0 && iv[j]) ok = 1'b0;
        if (s[j] === 1'b1 && !iv[j]) ok = 1'b0;
      end
      if (ok) begin
        if (f_bool(k, iv)) seen1 = 1'b1;
        else seen0 = 1'b1;
      end
    end
    if (seen0 && seen1) return 1'bx;
    return seen1;
  endfunction

  task automatic set_in(logic [3:0] v);
    {d, c, b, a} = v;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ce = 1'b1;
    set_in(4'($urandom_range(0, 15)));
    #1;
    for (int k = 0; k < N; k++) begin
      n_checks++;
`ifdef LUT_REG_OUT_EN
      if (q_v[k] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_q k=%0d got %b want 0", k, q_v[k]);
      end
`else
      if (q_v[k] !== ref_o(k, {d, c, b, a})) begin
        n_errors++;
        $display("FAIL reset_q k=%0d got %b want %b", k, q_v[k],
                 ref_o(k, {d, c, b, a}));
      end
`endif
    end
  endtask

  task automatic test_exhaustive;
    for (int i = 0; i < 16; i++) begin
      set_in(4'(i));
      #1;
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (o_v[k] !== ref_o(k, 4'(i))) begin
          n_errors++;
          $display("FAIL o_exh k=%0d idx=%0d got %b want %b", k, i, o_v[k],
                   ref_o(k, 4'(i)));
        end
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] x;
    logic [3:0] v;
    x = 64'd88172645463325252;
    for (int n = 0; n < 10000; n++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 7);
      x = x ^ (x << 17);
      v = {x[31], x[23], x[18], x[0]};
      set_in(v);
      #2;
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (o_v[k] !== ref_o(k, v)) begin
          n_errors++;
          $display("FAIL o_rand k=%0d n=%0d got %b want %b", k, n, o_v[k],
                   ref_o(k, v));
        end
      end
    end
  endtask

  task automatic test_xprop;
    logic probe;
    logic [3:0] xv [3];
    logic want [3];
    probe = 1'bx;
    if (!$isunknown(probe)) return;
    xv[0] = 4'b001x; want[0] = 1'b0;
    xv[1] = 4'b1xxx; want[1] = 1'b1;
    xv[2] = 4'b000x; want[2] = 1'bx;
    for (int t = 0; t < 3; t++) begin
      set_in(xv[t]);
      #1;
      n_checks++;
      if (o_v[0] !== want[t]) begin
        n_errors++;
        $display("FAIL o_x t=%0d got %b want %b", t, o_v[0], want[t]);
      end
      for (int k = 1; k < N; k++) begin
        n_checks++;
        if (o_v[k] !== ref_o(k, xv[t])) begin
          n_errors++;
          $display("FAIL o_xs k=%0d t=%0d got %b want %b", k, t, o_v[k],
                   ref_o(k, xv[t]));
        end
      end
    end
  endtask

`ifdef LUT_REG_OUT_EN
  task automatic test_registered;
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) exp_q[k] = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (q_v[k] !== 1'b0) begin
        n_errors++;
        $display("FAIL reg_rst k=%0d got %b want 0", k, q_v[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    ce = 1'b1;
    set_in(4'b0001);
    for (int k = 0; k < N; k++) exp_q[k] = ref_o(k, 4'b0001);
    @(negedge clk);
    n_checks++;
    if (q_v[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL reg_first got %b want 1", q_v[0]);
    end
    ce = 1'b0;
    set_in(4'b0011);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      n_checks++;
      if (q_v[k] !== exp_q[k]) begin
        n_errors++;
        $display("FAIL reg_hold k=%0d got %b want %b", k, q_v[k], exp_q[k]);
      end
    end
    for (int n = 0; n < 300; n++) begin
      set_in(4'($urandom_range(0, 15)));
      ce = 1'($urandom_range(0, 1));
      if (ce)
        for (int k = 0; k < N; k++) exp_q[k] = ref_o(k, {d, c, b, a});
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (q_v[k] !== exp_q[k]) begin
          n_errors++;
          $display("FAIL reg_rand k=%0d n=%0d got %b want %b", k, n,
                   q_v[k], exp_q[k]);
        end
      end
    end
    ce = 1'b1;
    set_in(4'b0001);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (q_v[0] !== 1'b0 || o_v[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL reg_async got q=%b o=%b want q=0 o=1", q_v[0], o_v[0]);
    end
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (q_v[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL reg_release got %b want 1", q_v[0]);
    end
  endtask
`else
  task automatic test_macro_off;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rst_n = 1'($urandom_range(0, 1));
      ce = 1'($urandom_range(0, 1));
      set_in(4'(i));
      #1;
      for (int k = 0; k < N; k++) begin
        n_checks++;
        if (q_v[k] !== ref_o(k, 4'(i))) begin
          n_errors++;
          $display("FAIL comb_q k=%0d idx=%0d got %b want %b", k, i,
                   q_v[k], ref_o(k, 4'(i)));
        end
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (q_v[0] !== ref_o(0, 4'(i))) begin
        n_errors++;
        $display("FAIL comb_q_clk idx=%0d got %b want %b", i, q_v[0],
                 ref_o(0, 4'(i)));
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    ce = 1'b1;
    set_in(4'b0000);
    test_reset;
    test_exhaustive;
    test_random;
    test_xprop;
    rst_n = 1'b1;
`ifdef LUT_REG_OUT_EN
    test_registered;
`else
    test_macro_off;
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
